// File: rtl/xillybus_rd32_arb_pkg.sv
// Shared types and header formatting for the 32-bit Xillybus read-stream arbiter.
package xillybus_rd32_arb_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Header word: magic, reserved nibble, source id, burst length.
  function automatic logic [31:0] make_hdr(input logic [3:0] id, input logic [15:0] len);
    return {HDR_MAGIC, 4'h0, id, len};
  endfunction

endpackage

// File: rtl/xillybus_rd32_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module xillybus_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    // Upper segment (after the pointer) wins over the wrapped lower segment.
    for (int i = 0; i < N; i++) begin
      if (!vld_o && req_i[i] && (i > int'(ptr_i))) begin
        vld_o    = 1'b1;
        idx_o    = IW'(i);
        gnt_o[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!vld_o && req_i[i] && (i <= int'(ptr_i))) begin
        vld_o    = 1'b1;
        idx_o    = IW'(i);
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xillybus_rd32_arbiter.sv
// Round-robin sharing of the Xillybus read_32 stream between NSRC FIFOs, header-prefixed bursts.
// Optional XILLYBUS_RD32_ARB_TIMEOUT_EN: aged sub-burst sources get partial grants.
module xillybus_rd32_arbiter
  import xillybus_rd32_arb_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int BURST_LEN = 16,
  parameter int LVL_W     = 10,
  parameter int TIMEOUT   = 256
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst,
  input  logic                    user_r_read_32_rden,
  output logic [31:0]             user_r_read_32_data,
  output logic                    user_r_read_32_empty,
  output logic                    user_r_read_32_eof,
  input  logic                    user_r_read_32_open,
  output logic [NSRC-1:0]         src_rden,
  input  logic [NSRC*32-1:0]      src_data,
  input  logic [NSRC*LVL_W-1:0]   src_level
);

  localparam int          IW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [31:0] BL32 = 32'(BURST_LEN);

  state_e      state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, sel_q, sel_d;
  logic        sel_hdr_q, sel_hdr_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] hdr_q, hdr_d;

  logic [NSRC-1:0][LVL_W-1:0] lvl;
  logic [NSRC-1:0][31:0]      sdat;
  logic [NSRC-1:0]            full_burst, aged, req, pick_gnt;
  logic [IW-1:0]              pick_idx;
  logic                       pick_vld, grant;
  logic [31:0]                lvl_g;
  logic [15:0]                len;

  assign lvl  = src_level;
  assign sdat = src_data;

  always_comb begin
    for (int i = 0; i < NSRC; i++) full_burst[i] = (32'(lvl[i]) >= BL32);
  end

  assign req = full_burst | aged;

  xillybus_rr_pick #(.N(NSRC), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign grant = (state_q == ST_IDLE) && user_r_read_32_open && pick_vld;

  always_comb begin
    lvl_g = '0;
    for (int i = 0; i < NSRC; i++) if (pick_gnt[i]) lvl_g = lvl_g | 32'(lvl[i]);
  end

  // Burst never exceeds what the source holds, so it cannot underflow.
  assign len = 16'((lvl_g < BL32) ? lvl_g : BL32);

`ifdef XILLYBUS_RD32_ARB_TIMEOUT_EN
  localparam int           AW   = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] AMAX = AW'(TIMEOUT);

  logic [NSRC-1:0][AW-1:0] age_q, age_d;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      aged[i]  = (age_q[i] == AMAX) && (lvl[i] != '0);
      age_d[i] = age_q[i];
      if ((lvl[i] == '0) || (grant && pick_gnt[i]) ||
          ((state_q != ST_IDLE) && (g_q == IW'(i))))
        age_d[i] = '0;
      else if (age_q[i] != AMAX)
        age_d[i] = age_q[i] + 1'b1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) age_q <= '0;
    else         age_q <= age_d;
  end
`else
  assign aged = '0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    sel_d     = sel_q;
    sel_hdr_d = sel_hdr_q;
    rem_d     = rem_q;
    hdr_d     = hdr_q;
    src_rden  = '0;
    if (!user_r_read_32_open) begin
      // Host closed the file: abandon the burst, leftovers stay in the FIFO.
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            g_d     = pick_idx;
            ptr_d   = pick_idx;
            rem_d   = len;
            hdr_d   = make_hdr(4'(pick_idx), len);
            state_d = ST_HDR;
          end
        end
        ST_HDR: begin
          if (user_r_read_32_rden) begin
            sel_hdr_d = 1'b1;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          if (user_r_read_32_rden && (rem_q != '0)) begin
            src_rden[g_q] = 1'b1;
            rem_d         = rem_q - 1'b1;
            sel_hdr_d     = 1'b0;
            sel_d         = g_q;
            if (rem_q == 16'd1) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IW'(NSRC - 1);
      g_q       <= '0;
      sel_q     <= '0;
      sel_hdr_q <= 1'b1;
      rem_q     <= '0;
      hdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      sel_q     <= sel_d;
      sel_hdr_q <= sel_hdr_d;
      rem_q     <= rem_d;
      hdr_q     <= hdr_d;
    end
  end

  assign user_r_read_32_empty = (state_q == ST_IDLE) || ((state_q == ST_DATA) && (rem_q == '0));
  // The select is registered so the word popped last cycle stays on the bus.
  assign user_r_read_32_data  = sel_hdr_q ? hdr_q : sdat[sel_q];
  assign user_r_read_32_eof   = 1'b0;

endmodule

// File: tb/tb_xillybus_rd32_arbiter.sv
// Directed + randomized bench for xillybus_rd32_arbiter with queue-based FIFOs and a stream model.
module tb_xillybus_rd32_arbiter;

  localparam int NSRC  = 4;
  localparam int BL    = 16;
  localparam int LVL_W = 10;
  localparam int TMO   = 8;

  logic                  bus_clk = 1'b0;
  logic                  bus_rst = 1'b1;
  logic                  rden = 1'b0;
  logic                  open = 1'b1;
  logic [31:0]           rdata;
  logic                  empty, eof;
  logic [NSRC-1:0]       src_rden;
  logic [NSRC*32-1:0]    src_data = '0;
  logic [NSRC*LVL_W-1:0] src_level = '0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0]     fq [NSRC][$];
  int              pushed [NSRC];
  int              seq    [NSRC];
  int              pulses [NSRC];
  int              m_ptr, m_cur, m_left;
  bit              allow_part = 1'b0;
  int              hdr_cyc [$];
  logic [NSRC-1:0] last_srd = '0;

  always #5 bus_clk = ~bus_clk;

  xillybus_rd32_arbiter #(
    .NSRC(NSRC), .BURST_LEN(BL), .LVL_W(LVL_W), .TIMEOUT(TMO)
  ) dut (
    .bus_clk              (bus_clk),
    .bus_rst              (bus_rst),
    .user_r_read_32_rden  (rden),
    .user_r_read_32_data  (rdata),
    .user_r_read_32_empty (empty),
    .user_r_read_32_eof   (eof),
    .user_r_read_32_open  (open),
    .src_rden             (src_rden),
    .src_data             (src_data),
    .src_level            (src_level)
  );

  function automatic logic [31:0] word_of(input int s, input int k);
    return {4'(s), 4'hC, 24'(k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd_lvl();
    for (int i = 0; i < NSRC; i++) src_level[i*LVL_W +: LVL_W] = LVL_W'(fq[i].size());
  endtask

  task automatic fill(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      fq[s].push_back(word_of(s, pushed[s]));
      pushed[s]++;
    end
    upd_lvl();
  endtask

  task automatic clear_q();
    for (int i = 0; i < NSRC; i++) begin
      fq[i].delete();
      pushed[i] = 0;
      seq[i]    = 0;
    end
    upd_lvl();
  endtask

  // One clock, entered and left at a falling edge; the bench FIFOs pop on src_rden.
  task automatic tick(input logic rd, output logic popped);
    popped = rd && open && !empty && !bus_rst;
    rden = rd;
    #1;
    last_srd = src_rden;
    @(posedge bus_clk);
    #1;
    for (int i = 0; i < NSRC; i++) begin
      if (last_srd[i]) begin
        checks++;
        assert (fq[i].size() > 0) else begin
          fails++;
          $error("FAIL underflow src=%0d observed=empty expected=nonempty", i);
        end
        if (fq[i].size() > 0) src_data[i*32 +: 32] = fq[i].pop_front();
        pulses[i]++;
      end
    end
    upd_lvl();
    cyc++;
    @(negedge bus_clk);
  endtask

  // Reference stream: next header goes to the first eligible source after the last grant.
  task automatic expect_word(input logic [31:0] w);
    int id, a, len;
    if (m_left == 0) begin
      id = -1;
      for (int k = 1; k <= NSRC; k++) begin
        a = pushed[(m_ptr + k) % NSRC] - seq[(m_ptr + k) % NSRC];
        if (id < 0 && (a >= BL || (allow_part && a > 0))) id = (m_ptr + k) % NSRC;
      end
      checks++;
      assert (id >= 0) else begin
        fails++;
        $error("FAIL spurious_word observed=%h expected=none", w);
      end
      if (id >= 0) begin
        a   = pushed[id] - seq[id];
        len = (a < BL) ? a : BL;
        chk("header", w, {8'hA5, 4'h0, 4'(id), 16'(len)});
        m_ptr  = id;
        m_cur  = id;
        m_left = len;
        hdr_cyc.push_back(cyc);
      end
    end else begin
      chk("data", w, word_of(m_cur, seq[m_cur]));
      seq[m_cur]++;
      m_left--;
    end
  endtask

  task automatic stream(input int nwords, input int pct, input int budget);
    int got, n;
    logic p, rd;
    logic [NSRC-1:0] es;
    got = 0;
    n = 0;
    while (got < nwords && n < budget) begin
      rd = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      es = '0;
      if (rd && open && !empty && m_left > 0) es[m_cur] = 1'b1;
      tick(rd, p);
      chk("src_rden", 32'(last_srd), 32'(es));
      if (p) begin
        expect_word(rdata);
        got++;
      end
      n++;
    end
    chk("stream_words", got, nwords);
  endtask

  task automatic do_reset();
    logic p;
    bus_rst = 1'b1;
    tick(1'b0, p);
    tick(1'b0, p);
    bus_rst = 1'b0;
    m_ptr  = NSRC - 1;
    m_left = 0;
  endtask

  initial begin
    logic p;
    logic [31:0] d0;
    int start, w, total, a, npop;

    @(negedge bus_clk);
    clear_q();
    tick(1'b1, p);
    tick(1'b1, p);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_data", rdata, 32'd0);
    chk("rst_eof", 32'(eof), 32'd0);
    chk("rst_srd", 32'(last_srd), 32'd0);
    bus_rst = 1'b0;
    m_ptr  = NSRC - 1;
    m_left = 0;

    // single full burst from source 0
    pulses[0] = 0;
    fill(0, 16);
    stream(17, 100, 60);
    chk("t1_pulses", pulses[0], 32'd16);
    chk("t1_empty_after", 32'(empty), 32'd1);

    // all sources deep, continuous rden
    do_reset();
    for (int i = 0; i < NSRC; i++) fill(i, 32);
    hdr_cyc.delete();
    stream(8 * 17, 100, 400);
    for (int k = 1; k < hdr_cyc.size(); k++)
      chk("t2_burst_spacing", hdr_cyc[k] - hdr_cyc[k-1], 32'd18);

    // trickle source below burst size
    do_reset();
    clear_q();
    fill(2, 5);
`ifdef XILLYBUS_RD32_ARB_TIMEOUT_EN
    allow_part = 1'b1;
    start = cyc;
    hdr_cyc.delete();
    stream(6, 100, 100);
    allow_part = 1'b0;
    w = (hdr_cyc.size() > 0) ? hdr_cyc[0] - start : 0;
    chk("t3_waited_timeout", 32'(w > TMO), 32'd1);
`else
    npop = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1'b1, p);
      if (p) npop++;
      chk("t3_no_grant_srd", 32'(last_srd), 32'd0);
    end
    chk("t3_no_pops", npop, 32'd0);
    chk("t3_still_empty", 32'(empty), 32'd1);
`endif

    // rden while empty in IDLE
    do_reset();
    clear_q();
    d0 = rdata;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, p);
      chk("t5_srd", 32'(last_srd), 32'd0);
      chk("t5_empty", 32'(empty), 32'd1);
      chk("t5_data_hold", rdata, d0);
    end

    // open drops mid-burst
    fill(0, 16);
    fill(1, 16);
    stream(4, 100, 20);
    open = 1'b0;
    tick(1'b1, p);
    chk("t4_srd_stop", 32'(last_srd), 32'd0);
    chk("t4_idle", 32'(empty), 32'd1);
    m_left = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, p);
      chk("t4_closed_empty", 32'(empty), 32'd1);
    end
    chk("t4_src0_left", fq[0].size(), 32'd13);
    open = 1'b1;
    stream(17, 100, 40);
    chk("t4_src0_kept", fq[0].size(), 32'd13);

    // reset in the middle of DATA
    do_reset();
    clear_q();
    fill(0, 16);
    stream(3, 100, 20);
    bus_rst = 1'b1;
    tick(1'b0, p);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_data", rdata, 32'd0);
    chk("t6_eof", 32'(eof), 32'd0);
    bus_rst = 1'b0;
    m_ptr  = NSRC - 1;
    m_left = 0;
    rden = 1'b1;
    #1;
    chk("t6_srd", 32'(src_rden), 32'd0);
    fill(0, 2);
    fill(3, 16);
    stream(17, 100, 40);

    // randomized fills, random consumer duty
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NSRC; i++) fill(i, 16 * $urandom_range(0, 3));
      total = 0;
      for (int i = 0; i < NSRC; i++) begin
        a = pushed[i] - seq[i];
        total += a + a / BL;
      end
      stream(total, $urandom_range(30, 100), total * 8 + 100);
      chk("rand_drained_empty", 32'(empty), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
